// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 32-bit ALU among NREQ requesters.
// One operation in flight: accept in IDLE, drive the ALU in EXEC, hold the response in RESP.
module alu_share_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [3*NREQ-1:0]    req_ctrl_i,
    input  logic [32*NREQ-1:0]   req_a_i,
    input  logic [32*NREQ-1:0]   req_b_i,
    output logic [2:0]           alu_ctrl_o,
    output logic [31:0]          alu_a_o,
    output logic [31:0]          alu_b_o,
    input  logic [31:0]          alu_result_i,
    input  logic                 alu_zero_i,
    input  logic                 alu_sign_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [31:0]          rsp_result_o,
    output logic                 rsp_zero_o,
    output logic                 rsp_sign_o,
    output logic                 rsp_err_o,
    output logic                 busy_o
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   last_grant_q, grant_q;
    logic [2:0]      op_ctrl_q;
    logic [31:0]     op_a_q, op_b_q;
    logic [31:0]     rsp_result_q;
    logic            rsp_zero_q, rsp_sign_q, rsp_err_q;
    logic            win_found_s, accept_s, capture_s;
    logic [IW-1:0]   win_idx_s, cand_s;

    // Codes the ALU implements: ADD, SUB, AND, OR, SLT.
    function automatic logic ctrl_unsupported(input logic [2:0] c);
        logic bad;
        case (c)
            3'b010, 3'b110, 3'b000, 3'b001, 3'b111: bad = 1'b0;
            default:                                bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IW'((int'(last_grant_q) + k) % NREQ);
            if (!win_found_s && req_valid_i[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant and datapath enables.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    req_ready_o[win_idx_s] = 1'b1;
                    accept_s               = 1'b1;
                    state_d                = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                capture_s = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready_i[grant_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch on accept and response capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IW'(NREQ - 1);
            grant_q      <= '0;
            op_ctrl_q    <= 3'd0;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            rsp_result_q <= 32'd0;
            rsp_zero_q   <= 1'b0;
            rsp_sign_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (accept_s) begin
                op_ctrl_q    <= req_ctrl_i[int'(win_idx_s) * 3 +: 3];
                op_a_q       <= req_a_i[int'(win_idx_s) * 32 +: 32];
                op_b_q       <= req_b_i[int'(win_idx_s) * 32 +: 32];
                grant_q      <= win_idx_s;
                last_grant_q <= win_idx_s;
            end
            if (capture_s) begin
                rsp_result_q <= alu_result_i;
                rsp_zero_q   <= alu_zero_i;
                rsp_sign_q   <= alu_sign_i;
                rsp_err_q    <= ctrl_unsupported(op_ctrl_q);
            end
        end
    end

    // Response valid decoded from registered state and grant.
    always_comb begin
        rsp_valid_o = '0;
        if (state_q == RESP) begin
            rsp_valid_o[grant_q] = 1'b1;
        end else begin
            rsp_valid_o = '0;
        end
    end

    assign alu_ctrl_o   = op_ctrl_q;
    assign alu_a_o      = op_a_q;
    assign alu_b_o      = op_b_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;
    assign rsp_sign_o   = rsp_sign_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with NREQ=2, a behavioural ALU and a response scoreboard.
module tb_alu_share_arbiter;

    localparam int NREQ = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [3*NREQ-1:0]   req_ctrl = '0;
    logic [32*NREQ-1:0]  req_a = '0;
    logic [32*NREQ-1:0]  req_b = '0;
    logic [2:0]          alu_ctrl;
    logic [31:0]         alu_a, alu_b, alu_result;
    logic                alu_zero, alu_sign;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic [31:0]         rsp_result;
    logic                rsp_zero, rsp_sign, rsp_err, busy;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        z;
        logic        s;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_ctrl_i   (req_ctrl),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .alu_ctrl_o   (alu_ctrl),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .alu_sign_i   (alu_sign),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_zero_o   (rsp_zero),
        .rsp_sign_o   (rsp_sign),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Shared combinational ALU
    always_comb begin
        case (alu_ctrl)
            3'b010:  alu_result = alu_a + alu_b;
            3'b110:  alu_result = alu_a - alu_b;
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b111:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
        alu_sign = alu_result[31];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        req_ctrl[3*idx +: 3] = c;
        req_a[32*idx +: 32]  = a;
        req_b[32*idx +: 32]  = b;
        req_valid[idx]       = 1'b1;
    endtask

    task automatic push(input int idx, input logic [31:0] res, input logic z, input logic s, input logic e);
        exp_t x;
        x.idx = idx; x.res = res; x.z = z; x.s = s; x.e = e;
        sb.push_back(x);
    endtask

    // Present a request, wait for its grant, then drop it after the transfer edge
    task automatic issue(input int idx, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic z, input logic s, input logic e);
        int n;
        @(negedge clk);
        set_req(idx, c, a, b);
        push(idx, res, z, s, e);
        #1;
        n = 0;
        while (!req_ready[idx] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("accept", 32'(req_ready), 32'(1 << idx));
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
    endtask

    // Wait for a response, compare against the scoreboard head, then handshake it
    task automatic collect();
        int   n;
        exp_t x;
        n = 0;
        @(negedge clk);
        while (rsp_valid == '0 && n < 20) begin
            @(negedge clk); n++;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            x = sb.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(1 << x.idx));
            check("rsp_result", rsp_result, x.res);
            check("rsp_zero", 32'(rsp_zero), 32'(x.z));
            check("rsp_sign", 32'(rsp_sign), 32'(x.s));
            check("rsp_err", 32'(rsp_err), 32'(x.e));
            rsp_ready[x.idx] = 1'b1;
            @(posedge clk); #1;
            rsp_ready[x.idx] = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] held;
        int          n;
        int          exp_g;

        // Reset values
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Single ADD with latency check
        @(negedge clk);
        set_req(0, 3'b010, 32'd5, 32'd7);
        push(0, 32'd12, 1'b0, 1'b0, 1'b0);
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1; req_valid[0] = 1'b0;
        @(negedge clk);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        collect();

        // Sign: SUB 1-2 on requester 1
        issue(1, 3'b110, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        collect();

        // Contention: grants must alternate 0,1,0,1
        @(negedge clk);
        set_req(0, 3'b110, 32'd3, 32'd3);
        set_req(1, 3'b001, 32'h0000_00F0, 32'h0000_000F);
        for (int op = 0; op < 4; op++) begin
            exp_g = op % 2;
            n = 0;
            #1;
            while (req_ready == '0 && n < 20) begin
                @(negedge clk); #1; n++;
            end
            check("rr_grant", 32'(req_ready), 32'(1 << exp_g));
            if (exp_g == 0) push(0, 32'd0, 1'b1, 1'b0, 1'b0);
            else            push(1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            collect();
        end
        req_valid = '0;

        // SLT and unsupported code
        issue(0, 3'b111, 32'd1, 32'd2, 32'd1, 1'b0, 1'b0, 1'b0);
        collect();
        issue(0, 3'b011, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b1);
        collect();
        @(negedge clk);
        check("unsup_idle", 32'(busy), 32'd0);

        // Backpressure with requester 1 waiting
        issue(0, 3'b010, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        set_req(1, 3'b000, 32'hFF00_FF00, 32'h0F0F_0F0F);
        held = rsp_result;
        check("bp_result_first", held, 32'd123);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_result_stable", rsp_result, held);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        push(0, 32'd123, 1'b0, 1'b0, 1'b0);
        collect();
        sb.delete();
        #1;
        check("bp_release_grant", 32'(req_ready), 32'h2);
        push(1, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1; req_valid[1] = 1'b0;
        collect();

        // Reset during EXEC
        issue(0, 3'b010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_alu_a", alu_a, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        set_req(0, 3'b001, 32'd4, 32'd3);
        set_req(1, 3'b001, 32'd8, 32'd8);
        #1;
        check("post_rst_grant", 32'(req_ready), 32'h1);
        push(0, 32'd7, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1; req_valid = '0;
        collect();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout vectors=%0d", vec_cnt);
        $fatal(1, "timeout");
    end

endmodule
